// File: rtl/dot_product_pkg.sv
// Shared types, default widths and the round-robin pick helper for dot_product_arbiter.
package dot_product_pkg;

  localparam int unsigned DEF_DATA_W = 8;
  localparam int unsigned DEF_LEN_W  = 4;
  localparam int unsigned DEF_ACC_W  = 2 * DEF_DATA_W + DEF_LEN_W;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  // First set bit of req searching upward from ptr+1, wrapping modulo n (n <= 8).
  function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr,
                                         input int unsigned n);
    logic [2:0] pick;
    logic [2:0] k;
    logic       found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned i = 1; i <= 8; i++) begin
      k = 3'(({29'd0, ptr} + i) % n);
      if (i <= n && !found && req[k]) begin
        pick  = k;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/mul8x8.sv
// Unsigned 8x8 shift-and-add multiplier, fully combinational.
module mul8x8 (
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  output logic [15:0] p
);

  always_comb begin
    p = '0;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p + (16'(a) << i);
    end
  end

endmodule

// File: rtl/dot_product_arbiter.sv
// Round-robin shared MAC: grants one requester at a time, accumulates its
// element-pair products and returns the tagged dot product.
module dot_product_arbiter
  import dot_product_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned LEN_W  = DEF_LEN_W,
  parameter int unsigned ACC_W  = 2 * DATA_W + LEN_W,
  localparam int unsigned ID_W  = $clog2(NREQ)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*LEN_W-1:0]  len,
  input  logic [NREQ*DATA_W-1:0] a_in,
  input  logic [NREQ*DATA_W-1:0] b_in,
  input  logic [NREQ-1:0]        in_valid,
  output logic [NREQ-1:0]        in_ready,
  output logic [NREQ-1:0]        grant,
  output logic [ACC_W-1:0]       result,
  output logic                   result_valid,
  output logic [ID_W-1:0]        result_id,
  output logic                   busy
);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   id_q, ptr_q, pick;
  logic [LEN_W-1:0]  len_q, cnt_q;
  logic [ACC_W-1:0]  acc_q, acc_nxt, result_q;
  logic [ID_W-1:0]   result_id_q;
  logic [DATA_W-1:0] a_sel, b_sel;
  logic [15:0]       prod;
  logic              hs, last;

  assign pick    = ID_W'(rr_pick(8'(req), 3'(ptr_q), NREQ));
  assign a_sel   = a_in[DATA_W*int'(id_q) +: DATA_W];
  assign b_sel   = b_in[DATA_W*int'(id_q) +: DATA_W];
  assign hs      = (state_q == StRun) && in_valid[id_q];
  assign last    = hs && (cnt_q == len_q);
  assign acc_nxt = acc_q + ACC_W'(prod);

  mul8x8 u_mul (
    .a (a_sel),
    .b (b_sel),
    .p (prod)
  );

  always_ff @(posedge clk) begin
    if (!reset) state_q <= StIdle;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (|req) state_d = StRun;
      StRun: begin
        if (!req[id_q])  state_d = StIdle;
        else if (last)   state_d = StDone;
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    grant        = '0;
    in_ready     = '0;
    busy         = (state_q == StRun) || (state_q == StDone);
    result_valid = (state_q == StDone);
    if (state_q == StRun) begin
      grant[id_q]    = 1'b1;
      in_ready[id_q] = 1'b1;
    end
  end

  // Result is captured with the final product so it is valid during the DONE pulse.
  always_ff @(posedge clk) begin
    if (!reset) begin
      id_q        <= '0;
      ptr_q       <= ID_W'(NREQ - 1);
      len_q       <= '0;
      cnt_q       <= '0;
      acc_q       <= '0;
      result_q    <= '0;
      result_id_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (|req) begin
            id_q  <= pick;
            len_q <= len[LEN_W*int'(pick) +: LEN_W];
            cnt_q <= '0;
            acc_q <= '0;
          end
        end
        StRun: begin
          if (!req[id_q]) begin
            ptr_q <= id_q;
          end else if (hs) begin
            acc_q <= acc_nxt;
            cnt_q <= cnt_q + LEN_W'(1);
            if (last) begin
              result_q    <= acc_nxt;
              result_id_q <= id_q;
            end
          end
        end
        StDone: ptr_q <= id_q;
        default: ;
      endcase
    end
  end

  assign result    = result_q;
  assign result_id = result_id_q;

endmodule

// File: tb/tb_dot_product_arbiter.sv
// Directed bench for dot_product_arbiter with hand-computed expected values.
module tb_dot_product_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [15:0] len;
  logic [31:0] a_in, b_in;
  logic [3:0]  in_valid, in_ready, grant;
  logic [19:0] result;
  logic        result_valid;
  logic [1:0]  result_id;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;
  int rv_cnt = 0;
  int busy_cnt = 0;
  int ready_bad = 0;
  logic [7:0] pa [16];
  logic [7:0] pb [16];

  always #5 clk = ~clk;

  dot_product_arbiter u_dut (
    .clk          (clk),
    .reset        (reset),
    .req          (req),
    .len          (len),
    .a_in         (a_in),
    .b_in         (b_in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .grant        (grant),
    .result       (result),
    .result_valid (result_valid),
    .result_id    (result_id),
    .busy         (busy)
  );

  always @(negedge clk) begin
    if (result_valid) rv_cnt++;
    if (busy) busy_cnt++;
    if ((in_ready & ~grant) != 4'd0) ready_bad++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Runs one full transaction on requester id using pa/pb, in_valid held high.
  task automatic do_txn(input int id, input int n, input logic [31:0] exp_res);
    int rv0;
    rv0 = rv_cnt;
    len[id*4 +: 4] = 4'(n - 1);
    req[id] = 1'b1;
    in_valid[id] = 1'b1;
    a_in[id*8 +: 8] = pa[0];
    b_in[id*8 +: 8] = pb[0];
    tick();
    check("txn_grant", 32'(grant), 32'(1 << id));
    check("txn_ready", 32'(in_ready), 32'(1 << id));
    for (int e = 0; e < n; e++) begin
      a_in[id*8 +: 8] = pa[e];
      b_in[id*8 +: 8] = pb[e];
      tick();
    end
    check("txn_rv", 32'(result_valid), 1);
    check("txn_result", 32'(result), exp_res);
    check("txn_id", 32'(result_id), 32'(id));
    check("txn_grant_done", 32'(grant), 0);
    req[id] = 1'b0;
    in_valid[id] = 1'b0;
    tick();
    check("txn_rv_after", 32'(result_valid), 0);
    check("txn_hold", 32'(result), exp_res);
    check("txn_pulses", 32'(rv_cnt - rv0), 1);
  endtask

  logic [3:0]  exp_g [13];
  logic [19:0] exp_r [4];

  initial begin
    exp_g = '{4'd1, 4'd0, 4'd0, 4'd2, 4'd0, 4'd0, 4'd4, 4'd0, 4'd0, 4'd8, 4'd0, 4'd0, 4'd1};
    exp_r = '{20'd2, 20'd6, 20'd12, 20'd20};
    reset = 1'b0; req = '0; len = '0; a_in = '0; b_in = '0; in_valid = '0;
    repeat (3) tick();
    check("rst_grant", 32'(grant), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_result", 32'(result), 0);
    reset = 1'b1;
    tick();

    // Single requester: (1,2)(3,4)(5,6)(7,8) -> 100
    pa[0] = 1; pb[0] = 2; pa[1] = 3; pb[1] = 4; pa[2] = 5; pb[2] = 6; pa[3] = 7; pb[3] = 8;
    do_txn(1, 4, 100);

    // Max values on requester 0: 16 * 255 * 255
    for (int i = 0; i < 16; i++) begin pa[i] = 8'd255; pb[i] = 8'd255; end
    busy_cnt = 0;
    do_txn(0, 16, 1040400);
    check("max_busy_cycles", 32'(busy_cnt), 17);

    // Stalls on requester 3: valid 1,0,0,1 with (10,10),(2,3) -> 106
    len[15:12] = 4'd1; req = 4'b1000; in_valid = 4'b1000;
    a_in[31:24] = 8'd10; b_in[31:24] = 8'd10;
    tick();
    check("stall_grant", 32'(grant), 8);
    tick();
    in_valid = 4'b0000;
    tick();
    check("stall_ready_held", 32'(in_ready), 8);
    tick();
    check("stall_no_rv", 32'(result_valid), 0);
    in_valid = 4'b1000; a_in[31:24] = 8'd2; b_in[31:24] = 8'd3;
    tick();
    check("stall_rv", 32'(result_valid), 1);
    check("stall_result", 32'(result), 106);
    req = '0; in_valid = '0;
    tick();
    check("stall_ready_bad", 32'(ready_bad), 0);

    // Fairness: all requesting, len 0, a=k+1, b=k+2
    len = '0; req = 4'b1111; in_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      a_in[k*8 +: 8] = 8'(k + 1);
      b_in[k*8 +: 8] = 8'(k + 2);
    end
    for (int i = 0; i < 13; i++) begin
      tick();
      check($sformatf("fair_grant_%0d", i), 32'(grant), 32'(exp_g[i]));
      if (i % 3 == 1) begin
        check($sformatf("fair_result_%0d", i), 32'(result), 32'(exp_r[i/3]));
        check($sformatf("fair_id_%0d", i), 32'(result_id), 32'(i / 3));
      end
    end
    req = '0; in_valid = '0;
    tick();
    check("fair_abort_idle", 32'(grant), 0);

    // Abort requester 2 after 2 of 5 elements; requester 3 must win next over 0
    len[11:8] = 4'd4; len[15:12] = 4'd4; req = 4'b0100; in_valid = 4'b0100;
    a_in[23:16] = 8'd9; b_in[23:16] = 8'd9;
    begin
      int rv0;
      rv0 = rv_cnt;
      tick();
      check("abort_grant", 32'(grant), 4);
      tick();
      tick();
      req = 4'b1001;
      tick();
      check("abort_idle", 32'(grant), 0);
      check("abort_busy", 32'(busy), 0);
      check("abort_result", 32'(result), 20);
      tick();
      check("abort_next_grant", 32'(grant), 8);
      check("abort_no_rv", 32'(rv_cnt - rv0), 0);
    end

    // Reset mid-RUN on requester 3
    in_valid = 4'b1000; a_in[31:24] = 8'd5; b_in[31:24] = 8'd5;
    tick();
    reset = 1'b0;
    tick();
    check("mrst_grant", 32'(grant), 0);
    check("mrst_ready", 32'(in_ready), 0);
    check("mrst_busy", 32'(busy), 0);
    check("mrst_rv", 32'(result_valid), 0);
    check("mrst_result", 32'(result), 0);
    check("mrst_id", 32'(result_id), 0);
    reset = 1'b1;
    tick();
    check("mrst_next_grant", 32'(grant), 1);
    req = '0; in_valid = '0;
    tick();
    check("total_pulses", 32'(rv_cnt), 7);
    check("ready_bad_total", 32'(ready_bad), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
